// File: rtl/comparator_1bit.sv
// comparator_1bit: registered per-bit magnitude flags plus MSB-first serial word comparison
module comparator_1bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             word_gt,
  output logic             word_lt,
  output logic             word_eq,
  output logic             word_valid,
  output logic [CNT_W-1:0] word_len
);
  typedef enum logic [1:0] {UND, GT, LT} dec_t;
  dec_t             dec, base_dec, fold_dec;
  logic             open, start;
  logic [CNT_W-1:0] cnt, base_cnt;
  always_comb begin
    start    = in_first | ~open;
    base_dec = start ? UND : dec;
    base_cnt = start ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
    fold_dec = (base_dec == UND && A != B) ? (A ? GT : LT) : base_dec;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A_gt_B     <= 1'b0;
      A_lt_B     <= 1'b0;
      A_eq_B     <= 1'b1;
      word_gt    <= 1'b0;
      word_lt    <= 1'b0;
      word_eq    <= 1'b0;
      word_valid <= 1'b0;
      word_len   <= '0;
      open       <= 1'b0;
      dec        <= UND;
      cnt        <= '0;
    end else begin
      word_valid <= in_valid & in_last;
      if (in_valid) begin
        A_gt_B <= A & ~B;
        A_lt_B <= ~A & B;
        A_eq_B <= ~(A ^ B);
        dec    <= fold_dec;
        cnt    <= base_cnt;
        open   <= ~in_last;
        if (in_last) begin
          word_gt  <= fold_dec == GT;
          word_lt  <= fold_dec == LT;
          word_eq  <= fold_dec == UND;
          word_len <= base_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_comparator_1bit.sv
// tb_comparator_1bit: directed and random stimulus against a queue-based word comparison model
module tb_comparator_1bit;
  logic clk = 0, rst_n = 0, A = 0, B = 0, in_valid = 0, in_first = 0, in_last = 0;
  logic A_gt_B, A_lt_B, A_eq_B, word_gt, word_lt, word_eq, word_valid;
  logic [7:0] word_len;
  int checks = 0, errors = 0;
  bit m_gt = 0, m_lt = 0, m_eq = 1, m_wgt = 0, m_wlt = 0, m_weq = 0, m_wv = 0, m_open = 0;
  int m_len = 0;
  bit qa[$], qb[$];

  comparator_1bit #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .A_eq_B(A_eq_B), .word_gt(word_gt),
    .word_lt(word_lt), .word_eq(word_eq), .word_valid(word_valid), .word_len(word_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit b, input bit v, input bit f, input bit l);
    int d;
    rst_n = ~r; A = a; B = b; in_valid = v; in_first = f; in_last = l;
    @(posedge clk);
    if (r) begin
      {m_gt, m_lt, m_eq} = 3'b001;
      {m_wgt, m_wlt, m_weq, m_wv, m_open} = '0;
      m_len = 0;
      qa.delete(); qb.delete();
    end else begin
      m_wv = 0;
      if (v) begin
        {m_gt, m_lt, m_eq} = {a & ~b, ~a & b, a == b};
        if (f || !m_open) begin qa.delete(); qb.delete(); end
        qa.push_back(a); qb.push_back(b);
        m_open = 1;
        if (l) begin
          d = 0;
          foreach (qa[i]) if (d == 0 && qa[i] != qb[i]) d = qa[i] ? 1 : -1;
          {m_wgt, m_wlt, m_weq} = {d > 0, d < 0, d == 0};
          m_len = qa.size() > 255 ? 255 : qa.size();
          m_wv = 1;
          m_open = 0;
        end
      end
    end
    #1;
    chk("A_gt_B", A_gt_B, m_gt);
    chk("A_lt_B", A_lt_B, m_lt);
    chk("A_eq_B", A_eq_B, m_eq);
    chk("word_gt", word_gt, m_wgt);
    chk("word_lt", word_lt, m_wlt);
    chk("word_eq", word_eq, m_weq);
    chk("word_valid", word_valid, m_wv);
    chk("word_len", word_len, m_len);
  endtask

  task automatic send_word(input logic [15:0] a, input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, a[i], b[i], 1, i == n - 1, i == 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    send_word(16'b1010, 16'b1001, 4);
    step(0, 0, 0, 0, 0, 0);
    send_word(16'b0110, 16'b0110, 4);
    send_word(16'b0011, 16'b0101, 4);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      step(0, i[0], ~i[0], 0, 1, 1);
      step(0, 4'b1100 >> i, 4'b1010 >> i, 1, i == 3, i == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0);
    send_word(16'b001, 16'b010, 3);
    step(0, 1, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) step(0, i == 258, 0, 1, i == 0, i == 259);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) == 0, $urandom_range(1), $urandom_range(1), $urandom_range(3) != 0,
           $urandom_range(7) == 0, $urandom_range(5) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
